output_stage: RTL and testbench
===============================

# output_stage

Per-output-port back end of the router. It arbitrates among the input stages that request this output, and locks the port to the winner from head flit to tail flit. It moves the owner's flits through a 2-entry output buffer onto the downstream link using a valid/ready handshake. It is the counterpart of the input stage: the input stage raises a per-port request and later drives flits through the crossbar, and this block grants that request, consumes those flits and releases the port on the tail.

## Interface
Parameters:
- `DW`, default `` `DW ``: flit width; flit type is carried in `[DW-1:DW-2]`.
- `N_IN`, default 5: number of requesting input stages.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rstn`, in, 1: reset, asynchronous and active-low.
- `req_i`, in, N_IN: bit k set means input k requests this output for a new packet.
- `grant_o`, out, N_IN: one-hot owner of the port; all-zero when the port is free.
- `valid_i`, in, N_IN: per-input flit valid from the crossbar.
- `data_i`, in, N_IN*DW: per-input flit; input k occupies `[k*DW +: DW]`.
- `ready_o`, out, N_IN: per-input accept.
- `valid_o`, out, 1: downstream flit valid.
- `data_o`, out, DW: downstream flit.
- `ready_i`, in, 1: downstream accept.

## Operation
- Flit type encoding in `[DW-1:DW-2]`:
  - 2'b10: head.
  - 2'b00: body.
  - 2'b01: tail.
  - 2'b11: single (head and tail in one flit).
- The state machine has two states, IDLE and BUSY. Reset enters IDLE.
- IDLE:
  - If `req_i` is nonzero, a round-robin arbiter picks the first set bit at or after pointer `rr` (ascending, wrapping from N_IN-1 to 0).
  - The winner is registered into `grant_o`, and the state becomes BUSY on the next edge.
  - If `req_i` is zero, the block stays in IDLE.
- BUSY:
  - `ready_o[owner]` equals `(count < 2)`. All other `ready_o` bits are 0.
  - A push occurs when `valid_i[owner] & ready_o[owner]`. The push writes `data_i[owner]` into the buffer.
  - `req_i` is ignored.
  - Flit type is not checked except for the release condition: a head flit arriving mid-packet is forwarded as an ordinary flit.
- Release:
  - Condition: a pushed flit has type tail or single.
  - On that edge, the state becomes IDLE, `grant_o` becomes 0, and `rr` becomes owner+1 (modulo N_IN).
- Output buffer:
  - 2-entry FIFO, `count` in 0..2.
  - `valid_o` = `(count != 0)`.
  - `data_o` is the oldest entry.
  - A pop occurs when `valid_o & ready_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - The buffer drains independently of the state machine, so flits of a released packet still leave after `grant_o` has dropped.
- In IDLE, all `ready_o` bits are 0 and non-head traffic on `valid_i` is never accepted.

## Timing
- Reset values:
  - `grant_o` = 0.
  - `ready_o` = 0.
  - `valid_o` = 0.
  - `data_o` = 0.
  - `count` = 0.
  - `rr` = 0.
  - State = IDLE.
- Reset asserted mid-packet aborts immediately: the buffer is emptied and the grant is dropped, with no flush.
- Grant latency:
  - `req_i[k]` sampled high in IDLE at edge t gives `grant_o[k]` = 1 after edge t.
  - `ready_o[k]` can therefore be high in the cycle after the request is sampled.
- Flit latency: a flit pushed at edge t is on `data_o` with `valid_o` = 1 after edge t. There is no combinational path from `data_i` to `data_o`.
- `ready_o` depends only on registered state and has no combinational path from `ready_i`.
- Throughput:
  - One flit per cycle sustained while `ready_i` = 1.
  - While `ready_i` = 0, exactly two flits are accepted, then `ready_o` drops.
- Packet gap:
  - A tail pushed at edge t means IDLE during cycle t+1.
  - The next grant is visible after edge t+1.
  - The minimum gap between packets on the owner side is therefore one cycle.
- Simultaneous requests: the grant goes to the lowest index at or above `rr`. Fairness is guaranteed because `rr` passes the served owner.
- Single-flit packet: release occurs on the same edge as its push.

## Test plan
- Reset, then `req_i`=5'b00100 and a 3-flit packet (head, body, tail) with `ready_i`=1:
  - `grant_o`=5'b00100 one cycle after the request.
  - The three flits appear on `data_o` in order, one cycle after each push.
  - `grant_o`=0 after the tail push.
- `req_i`=5'b10011 held constantly, each input sending single-flit packets: grants cycle 00001, 00010, 10000, 00001, with one IDLE cycle between consecutive grants.
- Downstream stall with `ready_i`=0 during a 4-flit packet:
  - Exactly 2 flits are accepted, then `ready_o[owner]`=0.
  - Raising `ready_i` resumes the packet with no loss, duplication or reordering.
- Owner's `req_i` drops and another input's `req_i` rises mid-packet: `grant_o` is unchanged until the tail, and the non-owner's `ready_o` stays 0 throughout.
- `rstn` pulsed low after the 2nd flit of a 5-flit packet with the buffer holding 2 flits: all outputs are 0 immediately (asynchronously), and after reset the next request is granted starting from `rr`=0.
- Push and pop in the same cycle at `count`=1 for 10 cycles: `count` stays 1, `valid_o` stays 1, and the data sequence is preserved.

Source files
------------

// File: rtl/output_stage.sv
// ---------------------------------------------------------------------------
// output_stage
//
// Back end of one router output port. Input stages raise req_i to ask for
// this port; a round-robin arbiter picks one, and the port stays locked to
// that owner from the head flit through the tail (or single) flit. Flits
// from the owner go through a 2-entry buffer onto the downstream link.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid must not depend on ready. Here ready_o is derived only
// from registered state, and valid_o only from the buffer occupancy.
//
// Ports
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   req_i      per-input request for a new packet
//   grant_o    one-hot owner, zero when the port is free
//   valid_i    per-input flit valid from the crossbar
//   data_i     per-input flit, input k at [k*DW +: DW]
//   ready_o    per-input accept (only the owner's bit can be high)
//   valid_o    downstream flit valid
//   data_o     downstream flit (oldest buffer entry)
//   ready_i    downstream accept
//   busy_dbg   FSM state (1 = BUSY)
//   count_dbg  buffer occupancy, 0..2
// ---------------------------------------------------------------------------
`ifndef DW
`define DW 16
`endif

module output_stage #(
  parameter int DW   = `DW,
  parameter int N_IN = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_IN-1:0]      req_i,
  output logic [N_IN-1:0]      grant_o,
  input  logic [N_IN-1:0]      valid_i,
  input  logic [N_IN*DW-1:0]   data_i,
  output logic [N_IN-1:0]      ready_o,
  output logic                 valid_o,
  output logic [DW-1:0]        data_o,
  input  logic                 ready_i,
  output logic                 busy_dbg,
  output logic [1:0]           count_dbg
);

  localparam int RRW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [RRW-1:0]  rr;

  // Output buffer
  logic [DW-1:0]   mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;

  // Arbiter
  logic [N_IN-1:0] arb_gnt;
  logic            arb_found;
  logic [RRW:0]    arb_pos;

  // Owner selection
  logic [RRW-1:0]  owner_idx;
  logic [RRW-1:0]  owner_next;
  logic [DW-1:0]   owner_data;
  logic            owner_valid;

  logic            push;
  logic            pop;
  logic            push_last;

  // Round robin: scan positions rr, rr+1, ... wrapping at N_IN, and take the
  // first requester found.
  always_comb begin
    arb_gnt   = '0;
    arb_found = 1'b0;
    arb_pos   = '0;
    for (int i = 0; i < N_IN; i++) begin
      arb_pos = {1'b0, rr} + (RRW+1)'(i);
      if (arb_pos >= (RRW+1)'(N_IN)) begin
        arb_pos = arb_pos - (RRW+1)'(N_IN);
      end
      if (!arb_found && req_i[arb_pos[RRW-1:0]]) begin
        arb_gnt[arb_pos[RRW-1:0]] = 1'b1;
        arb_found                 = 1'b1;
      end
    end
  end

  // grant_o is one-hot (or zero), so an OR-free priority mux is sufficient.
  always_comb begin
    owner_idx   = '0;
    owner_data  = '0;
    owner_valid = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_o[i]) begin
        owner_idx   = RRW'(i);
        owner_data  = data_i[i*DW +: DW];
        owner_valid = valid_i[i];
      end
    end
  end

  assign owner_next = (owner_idx == RRW'(N_IN-1)) ? '0 : owner_idx + 1'b1;

  assign ready_o   = (state == BUSY && count < 2'd2) ? grant_o : '0;
  assign push      = (state == BUSY) && owner_valid && (count < 2'd2);
  assign valid_o   = (count != 2'd0);
  assign pop       = valid_o && ready_i;
  assign data_o    = mem[rd_ptr];

  // Tail (01) and single (11) share bit DW-2; either one ends the packet.
  assign push_last = push && owner_data[DW-2];

  assign busy_dbg  = (state == BUSY);
  assign count_dbg = count;

  // Port ownership FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      grant_o <= '0;
      rr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_o <= arb_gnt;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (push_last) begin
            grant_o <= '0;
            rr      <= owner_next;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

  // Output buffer; drains regardless of FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= owner_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_output_stage.sv
// ---------------------------------------------------------------------------
// tb_output_stage
//
// Bench for output_stage. Inputs are driven 1 time unit after the rising
// edge; outputs are sampled on the falling edge or 1-2 units after the
// rising edge. Every flit accepted by the DUT is pushed to exp_q and popped
// and compared when it leaves on the downstream link.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_output_stage;

  localparam int DW   = 16;
  localparam int N_IN = 5;

  logic                 clk;
  logic                 rstn;
  logic [N_IN-1:0]      req_i;
  logic [N_IN-1:0]      grant_o;
  logic [N_IN-1:0]      valid_i;
  logic [N_IN*DW-1:0]   data_i;
  logic [N_IN-1:0]      ready_o;
  logic                 valid_o;
  logic [DW-1:0]        data_o;
  logic                 ready_i;
  logic                 busy_dbg;
  logic [1:0]           count_dbg;

  int n_pass;
  int n_total;
  int n_acc;

  logic [DW-1:0] exp_q[$];

  output_stage #(.DW(DW), .N_IN(N_IN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (req_i),
    .grant_o   (grant_o),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .ready_i   (ready_i),
    .busy_dbg  (busy_dbg),
    .count_dbg (count_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn    = 1'b0;
    req_i   = '0;
    valid_i = '0;
    data_i  = '0;
    ready_i = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  // A pop happens at the next rising edge whenever valid_o & ready_i is
  // seen here.
  always @(negedge clk) begin
    logic [DW-1:0] exp_v;
    if (rstn && valid_o && ready_i) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %h required no output", data_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (data_o !== exp_v) begin
          $display("FAIL sb_data: got %h required %h", data_o, exp_v);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic request(input logic [N_IN-1:0] mask, input logic [N_IN-1:0] exp_g);
    req_i = mask;
    @(posedge clk);
    #1;
    n_total++;
    if (grant_o !== exp_g) $display("FAIL grant: got %b required %b", grant_o, exp_g);
    else n_pass++;
  endtask

  task automatic check_grant(input logic [N_IN-1:0] exp_g);
    @(posedge clk);
    #1;
    n_total++;
    if (grant_o !== exp_g) $display("FAIL grant_rr: got %b required %b", grant_o, exp_g);
    else n_pass++;
  endtask

  // Sends one packet of len flits from input k. chk_lat checks that each
  // flit is on data_o right after its push edge (only valid with ready_i=1).
  task automatic send_packet(input int k, input int len, input bit chk_lat);
    logic [1:0]      t;
    logic [DW-1:0]   f;
    logic [N_IN-1:0] oh;
    bit              acc;
    oh = '0;
    oh[k] = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (len == 1)           t = 2'b11;
      else if (i == 0)        t = 2'b10;
      else if (i == len - 1)  t = 2'b01;
      else                    t = 2'b00;
      f = {t, 14'($urandom_range(0, 16383))};
      valid_i[k] = 1'b1;
      data_i[k*DW +: DW] = f;
      acc = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (ready_o[k]) begin
          acc = 1'b1;
          break;
        end
      end
      n_total++;
      if (!acc) begin
        $display("FAIL accept_timeout: got no ready_o[%0d] required accept within 100 cycles", k);
        valid_i[k] = 1'b0;
        return;
      end
      n_pass++;
      n_total++;
      if (grant_o !== oh) $display("FAIL grant_hold: got %b required %b", grant_o, oh);
      else n_pass++;
      n_total++;
      if ((ready_o & ~oh) !== '0) $display("FAIL ready_nonowner: got %b required %b", ready_o, oh);
      else n_pass++;
      exp_q.push_back(f);
      n_acc++;
      @(posedge clk);
      #1;
      if (chk_lat) begin
        n_total++;
        if (valid_o !== 1'b1 || data_o !== f)
          $display("FAIL flit_latency: got v=%b d=%h required v=1 d=%h", valid_o, data_o, f);
        else n_pass++;
      end
    end
    valid_i[k] = 1'b0;
    n_total++;
    if (grant_o !== '0 || busy_dbg !== 1'b0)
      $display("FAIL release: got grant=%b busy=%b required grant=0 busy=0", grant_o, busy_dbg);
    else n_pass++;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && valid_o == 1'b0) break;
    end
    n_total++;
    if (exp_q.size() != 0 || valid_o !== 1'b0)
      $display("FAIL drain: got %0d pending valid_o=%b required 0 pending valid_o=0", exp_q.size(), valid_o);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_total++;
    if (grant_o !== '0) $display("FAIL reset_grant: got %b required 0", grant_o); else n_pass++;
    n_total++;
    if (ready_o !== '0) $display("FAIL reset_ready: got %b required 0", ready_o); else n_pass++;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b required 0", valid_o); else n_pass++;
    n_total++;
    if (data_o !== '0) $display("FAIL reset_data: got %h required 0", data_o); else n_pass++;
    n_total++;
    if (count_dbg !== 2'd0 || busy_dbg !== 1'b0)
      $display("FAIL reset_state: got count=%0d busy=%b required 0/0", count_dbg, busy_dbg);
    else n_pass++;
  endtask

  task automatic test_basic_packet();
    ready_i = 1'b1;
    request(5'b00100, 5'b00100);
    req_i = '0;
    send_packet(2, 3, 1'b1);
    wait_drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    ready_i = 1'b1;
    request(5'b10011, 5'b00001);
    send_packet(0, 1, 1'b0);
    check_grant(5'b00010);
    send_packet(1, 1, 1'b0);
    check_grant(5'b10000);
    send_packet(4, 1, 1'b0);
    check_grant(5'b00001);
    req_i = '0;
    send_packet(0, 1, 1'b0);
    wait_drain();
  endtask

  // rr = 1 here, so input 1 wins.
  task automatic test_stall();
    ready_i = 1'b0;
    n_acc = 0;
    request(5'b00010, 5'b00010);
    req_i = '0;
    fork
      send_packet(1, 4, 1'b0);
      begin
        repeat (6) @(negedge clk);
        n_total++;
        if (n_acc != 2) $display("FAIL stall_accepted: got %0d required 2", n_acc); else n_pass++;
        n_total++;
        if (ready_o !== '0) $display("FAIL stall_ready: got %b required 0", ready_o); else n_pass++;
        n_total++;
        if (count_dbg !== 2'd2 || valid_o !== 1'b1)
          $display("FAIL stall_count: got count=%0d valid=%b required 2/1", count_dbg, valid_o);
        else n_pass++;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    wait_drain();
  endtask

  // rr = 2 here. Input 3 owns; input 0 requests and drives valid mid-packet.
  task automatic test_owner_switch();
    ready_i = 1'b1;
    request(5'b01000, 5'b01000);
    req_i = 5'b00001;
    valid_i[0] = 1'b1;
    data_i[0 +: DW] = 16'h0BAD;
    send_packet(3, 4, 1'b0);
    valid_i[0] = 1'b0;
    check_grant(5'b00001);
    req_i = '0;
    send_packet(0, 1, 1'b0);
    wait_drain();
  endtask

  // rr = 1 here; input 2 wins. Reset after two flits with the buffer full.
  task automatic test_reset_mid_packet();
    bit ok;
    ready_i = 1'b0;
    request(5'b00100, 5'b00100);
    req_i = '0;
    for (int i = 0; i < 2; i++) begin
      valid_i[2] = 1'b1;
      data_i[2*DW +: DW] = (i == 0) ? 16'h8123 : 16'h0456;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ready_o[2]) begin
          ok = 1'b1;
          break;
        end
      end
      n_total++;
      if (!ok) $display("FAIL rst_push: got no ready_o[2] required accept"); else n_pass++;
      @(posedge clk);
      #1;
    end
    valid_i = '0;
    n_total++;
    if (count_dbg !== 2'd2) $display("FAIL rst_prefill: got %0d required 2", count_dbg); else n_pass++;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_total++;
    if (grant_o !== '0 || ready_o !== '0 || valid_o !== 1'b0 || data_o !== '0 || count_dbg !== 2'd0)
      $display("FAIL rst_async: got g=%b r=%b v=%b d=%h c=%0d required all 0",
               grant_o, ready_o, valid_o, data_o, count_dbg);
    else n_pass++;
    ready_i = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // With rr back at 0, input 0 beats input 1.
    request(5'b00011, 5'b00001);
    req_i = '0;
    send_packet(0, 1, 1'b0);
    wait_drain();
  endtask

  // rr = 1 here; input 1 wins. Head is pushed with ready_i=0 to reach
  // count=1, then push and pop overlap for 10 cycles.
  task automatic test_push_pop();
    bit ok;
    ready_i = 1'b0;
    n_acc = 0;
    request(5'b00010, 5'b00010);
    req_i = '0;
    fork
      send_packet(1, 11, 1'b0);
      begin
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk);
          #2;
          if (count_dbg == 2'd1) begin
            ok = 1'b1;
            break;
          end
        end
        n_total++;
        if (!ok) $display("FAIL pp_first: got count=%0d required 1", count_dbg); else n_pass++;
        ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          n_total++;
          if (count_dbg !== 2'd1 || valid_o !== 1'b1)
            $display("FAIL pp_steady: got count=%0d valid=%b required 1/1", count_dbg, valid_o);
          else n_pass++;
        end
      end
    join
    wait_drain();
  endtask

  // ---------------- main ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    n_acc   = 0;
    rstn    = 1'b0;
    req_i   = '0;
    valid_i = '0;
    data_i  = '0;
    ready_i = 1'b0;
    test_reset();
    test_basic_packet();
    test_round_robin();
    test_stall();
    test_owner_switch();
    test_reset_mid_packet();
    test_push_pop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
